// File: rtl/clm_aes_host_ctrl_pkg.sv
// Shared types for the CLM AES host-side controller.
package clm_aes_host_ctrl_pkg;

   localparam int D      = 4;
   localparam int RED_W  = 8 + D;
   localparam int N_RAND = 23;
   localparam int RAND_W = N_RAND * RED_W;

   typedef logic [RED_W-1:0]         red_poly_t;
   typedef red_poly_t                p_det_t;
   typedef red_poly_t [0:N_RAND-1]   rand_vec_t;
   typedef logic [1:0]               word_idx_t;

   typedef enum logic [2:0] {
      COLLECT,
      ARM,
      LAUNCH,
      WAIT,
      DRAIN
   } host_state_t;

endpackage

// File: rtl/clm_aes_host_ctrl_if.sv
// Host-to-core bundle for one CLM AES core instance.
interface clm_aes_host_ctrl_if #(
   parameter int d = 4
);
   import clm_aes_host_ctrl_pkg::*;

   logic [127:0]          core_plaintext;
   logic [127:0]          core_key;
   logic [23*(8+d)-1:0]   core_random_vect;
   p_det_t                core_p_det;
   logic                  core_drdy_i;
   logic                  core_drdy_o;
   logic [127:0]          core_ciphertext;

   modport master (
      output core_plaintext, core_key, core_random_vect, core_p_det, core_drdy_i,
      input  core_drdy_o, core_ciphertext
   );

   modport slave (
      input  core_plaintext, core_key, core_random_vect, core_p_det, core_drdy_i,
      output core_drdy_o, core_ciphertext
   );

endinterface

// File: rtl/clm_aes_host_ctrl_word_buf.sv
// 4x32 word register with indexed word write, optional 128-bit parallel load
// (load has priority) and a flat 128-bit view. Word k sits at bits [32k+:32].
module host_word_buf
   import clm_aes_host_ctrl_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  word_idx_t     idx,
   input  logic [31:0]   wdata,
   input  logic          load,
   input  logic [127:0]  ldata,
   output logic [127:0]  q
);

   // word write or full parallel load
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      q <= '0;
      else if (load) q <= ldata;
      else if (we)   q[{idx, 5'b00000} +: 32] <= wdata;
   end

endmodule

// File: rtl/clm_aes_host_ctrl.sv
// Initiator for the CLM AES core: gathers key/plaintext words, attaches fresh
// randomness, launches the core and streams the ciphertext back out.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   COLLECT | accept key words any time, plaintext once key is valid
//   ARM     | waiting for rand_valid; latch rand_i/p_det_i on it
//   LAUNCH  | one-cycle core_drdy_i pulse, wait counter cleared
//   WAIT    | waiting for core_drdy_o, abort with err at TIMEOUT
//   DRAIN   | present ciphertext words 0..3 on the output stream
module clm_aes_host_ctrl
   import clm_aes_host_ctrl_pkg::*;
#(
   parameter int d       = D,
   parameter int TIMEOUT = 1023
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_data,
   input  logic                 in_key,
   input  logic                 rand_valid,
   output logic                 rand_ack,
   input  logic [23*(8+d)-1:0]  rand_i,
   input  p_det_t               p_det_i,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_data,
   output logic                 busy,
   output logic                 err,
   clm_aes_host_ctrl_if.master  core
);

   localparam int            CW     = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

   host_state_t    state, state_n;
   word_idx_t      key_cnt, pt_cnt, out_cnt;
   logic           key_valid;
   logic [CW-1:0]  wait_cnt;
   rand_vec_t      rand_q;
   p_det_t         p_det_q;
   logic [127:0]   key_q, pt_q, ct_q;
   logic           key_wr, pt_wr, ct_load, drdy_i, timed_out;

   assign in_ready  = (state == COLLECT) && (in_key || key_valid);
   assign key_wr    = in_valid && in_ready && in_key;
   assign pt_wr     = in_valid && in_ready && !in_key;
   assign ct_load   = (state == WAIT) && core.core_drdy_o;
   // drdy_o in the same cycle as the terminal count takes precedence
   assign timed_out = (state == WAIT) && !core.core_drdy_o && (wait_cnt == TO_VAL);

   assign busy     = (state != COLLECT);
   assign out_data = ct_q[{out_cnt, 5'b00000} +: 32];

   assign core.core_plaintext   = pt_q;
   assign core.core_key         = key_q;
   assign core.core_random_vect = rand_q;
   assign core.core_p_det       = p_det_q;
   assign core.core_drdy_i      = drdy_i;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= COLLECT;
      else      state <= state_n;
   end

   // next state and per-state strobes
   always_comb begin
      state_n   = state;
      rand_ack  = 1'b0;
      drdy_i    = 1'b0;
      out_valid = 1'b0;
      case (state)
         COLLECT: if (pt_wr && (pt_cnt == 2'd3)) state_n = ARM;
         ARM: begin
            if (rand_valid) begin
               rand_ack = 1'b1;
               state_n  = LAUNCH;
            end
         end
         LAUNCH: begin
            drdy_i  = 1'b1;
            state_n = WAIT;
         end
         WAIT: begin
            if (core.core_drdy_o) state_n = DRAIN;
            else if (timed_out)   state_n = COLLECT;
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready && (out_cnt == 2'd3)) state_n = COLLECT;
         end
         default: state_n = COLLECT;
      endcase
   end

   // word counters, key_valid, wait counter, randomness latch, sticky err
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_cnt   <= '0;
         pt_cnt    <= '0;
         out_cnt   <= '0;
         key_valid <= 1'b0;
         wait_cnt  <= '0;
         rand_q    <= '0;
         p_det_q   <= '0;
         err       <= 1'b0;
      end else begin
         if (key_wr) begin
            key_cnt <= key_cnt + 2'd1;
            if (key_cnt == 2'd0) key_valid <= 1'b0;
            if (key_cnt == 2'd3) key_valid <= 1'b1;
         end
         if (pt_wr)                  pt_cnt  <= pt_cnt + 2'd1;
         if (out_valid && out_ready) out_cnt <= out_cnt + 2'd1;
         if (rand_ack) begin
            rand_q  <= rand_i;
            p_det_q <= p_det_i;
         end
         if (state == LAUNCH)    wait_cnt <= '0;
         else if (state == WAIT) wait_cnt <= wait_cnt + CW'(1);
         if (timed_out) err <= 1'b1;
      end
   end

   host_word_buf u_key_buf (
      .clk(clk), .rst(rst), .we(key_wr), .idx(key_cnt), .wdata(in_data),
      .load(1'b0), .ldata(128'd0), .q(key_q)
   );

   host_word_buf u_pt_buf (
      .clk(clk), .rst(rst), .we(pt_wr), .idx(pt_cnt), .wdata(in_data),
      .load(1'b0), .ldata(128'd0), .q(pt_q)
   );

   host_word_buf u_ct_buf (
      .clk(clk), .rst(rst), .we(1'b0), .idx(2'd0), .wdata(32'd0),
      .load(ct_load), .ldata(core.core_ciphertext), .q(ct_q)
   );

endmodule

// File: tb/tb_clm_aes_host_ctrl.sv
// Bench for clm_aes_host_ctrl: a table of blocks (key/plaintext/randomness,
// core latency, sink ready pattern, expected ciphertext) driven through the
// controller against a stand-in core, plus reset sequences.
module tb_clm_aes_host_ctrl;
   import clm_aes_host_ctrl_pkg::*;

   localparam int TO = 15;
   localparam logic [127:0] FIPS_KEY = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
   localparam logic [127:0] FIPS_PT  = 128'hffeeddcc_bbaa9988_77665544_33221100;
   localparam logic [127:0] FIPS_CT  = 128'h5ac5b470_80b7cdd8_30047b6a_d8e0c469;
   localparam int N_BLK = 11;

   typedef struct {
      logic              new_key;
      logic [127:0]      key;
      logic [127:0]      pt;
      logic [RAND_W-1:0] rnd;
      logic [RED_W-1:0]  pdet;
      int                arm_hold;
      int                lat;
      logic [15:0]       rdy;
      logic              exp_timeout;
      logic [127:0]      exp_ct;
   } blk_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid, in_ready, in_key;
   logic [31:0]       in_data;
   logic              rand_valid, rand_ack;
   logic [RAND_W-1:0] rand_i;
   p_det_t            p_det_i;
   logic              out_valid, out_ready;
   logic [31:0]       out_data;
   logic              busy, err;

   int   errors = 0;
   int   checks = 0;
   logic err_exp = 1'b0;
   blk_t tbl [N_BLK];

   clm_aes_host_ctrl_if #(.d(4)) cif ();

   clm_aes_host_ctrl #(.d(4), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
      .rand_valid(rand_valid), .rand_ack(rand_ack), .rand_i(rand_i), .p_det_i(p_det_i),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .err(err),
      .core(cif)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin errors++; $display("FAIL %s: got %b want %b", name, act, exp); end
   endtask
   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin errors++; $display("FAIL %s: got %h want %h", name, act, exp); end
   endtask
   task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin errors++; $display("FAIL %s: got %h want %h", name, act, exp); end
   endtask
   task automatic chkrv(input string name, input logic [RAND_W-1:0] act, input logic [RAND_W-1:0] exp);
      checks++;
      if (act !== exp) begin errors++; $display("FAIL %s: got %h want %h", name, act, exp); end
   endtask
   task automatic chkpd(input string name, input logic [RED_W-1:0] act, input logic [RED_W-1:0] exp);
      checks++;
      if (act !== exp) begin errors++; $display("FAIL %s: got %h want %h", name, act, exp); end
   endtask
   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin errors++; $display("FAIL %s: got %0d want %0d", name, act, exp); end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [RAND_W-1:0] rand_rv();
      logic [287:0] t;
      for (int j = 0; j < 9; j++) t[32*j +: 32] = $urandom();
      return t[RAND_W-1:0];
   endfunction

   // Stand-in core transform: the real AES result for the FIPS-197 vector,
   // otherwise an order-sensitive mix of key and plaintext.
   function automatic logic [127:0] ct_fn(input logic [127:0] key, input logic [127:0] pt);
      if (key == FIPS_KEY && pt == FIPS_PT) return FIPS_CT;
      return pt ^ {key[95:0], key[127:96]} ^ 128'hc3a5_5a3c_0f1e_2d4b_8796_a5b4_c3d2_e1f0;
   endfunction

   function automatic blk_t mk(input logic nk, input logic [127:0] key, input logic [127:0] pt,
                               input int hold, input int lat, input logic [15:0] rdy, input logic to);
      blk_t b;
      b.new_key = nk;  b.key = key;  b.pt = pt;
      b.rnd = rand_rv();  b.pdet = RED_W'($urandom());
      b.arm_hold = hold;  b.lat = lat;  b.rdy = rdy;  b.exp_timeout = to;
      b.exp_ct = ct_fn(key, pt);
      return b;
   endfunction

   // Called just after a falling edge; returns on the falling edge after acceptance.
   task automatic send_word(input logic [31:0] w, input logic k);
      int n = 0;
      in_valid = 1'b1; in_data = w; in_key = k;
      #1;
      while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
      chk1("send_word_ready", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic reset_state_checks();
      in_key = 1'b0; #1;
      chk1("rst_in_ready_pt", in_ready, 1'b0);
      in_key = 1'b1; #1;
      chk1("rst_in_ready_key", in_ready, 1'b1);
      in_key = 1'b0;
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk32("rst_out_data", out_data, 32'd0);
      chk1("rst_rand_ack", rand_ack, 1'b0);
      chk1("rst_drdy_i", cif.core_drdy_i, 1'b0);
      chk128("rst_core_key", cif.core_key, 128'd0);
      chk128("rst_core_pt", cif.core_plaintext, 128'd0);
      chkrv("rst_core_rv", cif.core_random_vect, '0);
      chkpd("rst_core_pdet", cif.core_p_det, '0);
   endtask

   task automatic run_block(input blk_t b);
      logic [127:0] stub_ct;
      int idx, n;
      if (b.new_key) for (int k = 0; k < 4; k++) send_word(b.key[32*k +: 32], 1'b1);
      rand_i = b.rnd; p_det_i = b.pdet; rand_valid = (b.arm_hold == 0);
      for (int k = 0; k < 4; k++) send_word(b.pt[32*k +: 32], 1'b0);
      for (int i = 0; i < b.arm_hold; i++) begin
         #1;
         chk1("arm_hold_ack", rand_ack, 1'b0);
         chk1("arm_hold_drdy", cif.core_drdy_i, 1'b0);
         chk1("arm_hold_busy", busy, 1'b1);
         @(negedge clk);
      end
      rand_valid = 1'b1; #1;
      chk1("rand_ack_pulse", rand_ack, 1'b1);
      chk1("drdy_not_early", cif.core_drdy_i, 1'b0);
      @(negedge clk);
      rand_valid = 1'b0; rand_i = ~rand_i; p_det_i = ~p_det_i; #1;
      chk1("drdy_i_launch", cif.core_drdy_i, 1'b1);
      chk1("rand_ack_once", rand_ack, 1'b0);
      chk128("core_key", cif.core_key, b.key);
      chk128("core_plaintext", cif.core_plaintext, b.pt);
      chkrv("core_random_vect", cif.core_random_vect, b.rnd);
      chkpd("core_p_det", cif.core_p_det, b.pdet);
      stub_ct = ct_fn(cif.core_key, cif.core_plaintext);
      if (b.exp_timeout) begin
         for (int i = 1; i <= TO + 1; i++) begin
            @(negedge clk); #1;
            chk1("to_err_before", err, err_exp);
            chk1("to_busy", busy, 1'b1);
            chk1("to_drdy_once", cif.core_drdy_i, 1'b0);
         end
         @(negedge clk); #1;
         err_exp = 1'b1;
         chk1("to_err_set", err, 1'b1);
         chk1("to_back_collect", busy, 1'b0);
         chk1("to_no_output", out_valid, 1'b0);
         chk128("to_key_kept", cif.core_key, b.key);
         in_key = 1'b0; #1;
         chk1("to_key_valid_kept", in_ready, 1'b1);
      end else begin
         for (int i = 0; i < b.lat; i++) begin
            @(negedge clk); #1;
            chk1("wait_drdy_once", cif.core_drdy_i, 1'b0);
            chk1("wait_no_out", out_valid, 1'b0);
         end
         @(negedge clk);
         cif.core_drdy_o = 1'b1; cif.core_ciphertext = stub_ct; #1;
         chk1("wait_drdy_low", cif.core_drdy_i, 1'b0);
         @(negedge clk);
         cif.core_drdy_o = 1'b0; cif.core_ciphertext = rand128(); #1;
         chkrv("rv_stable", cif.core_random_vect, b.rnd);
         idx = 0; n = 0;
         while (idx < 4 && n < 100) begin
            out_ready = b.rdy[n % 16]; #1;
            chk1("out_valid", out_valid, 1'b1);
            chk32("out_data", out_data, b.exp_ct[32*idx +: 32]);
            if (out_ready) idx++;
            @(negedge clk); n++;
         end
         chki("drain_words", idx, 4);
         out_ready = 1'b0; #1;
         chk1("drain_done_valid", out_valid, 1'b0);
         chk1("drain_done_busy", busy, 1'b0);
      end
      chk1("err_flag", err, err_exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] cur_key, k;
      logic nk;
      rst = 1'b0; in_valid = 1'b0; in_data = '0; in_key = 1'b0;
      rand_valid = 1'b0; rand_i = '0; p_det_i = '0; out_ready = 1'b0;
      cif.core_drdy_o = 1'b0; cif.core_ciphertext = '0;

      tbl[0] = mk(1'b1, FIPS_KEY, FIPS_PT, 0, 3, 16'hFFFF, 1'b0);
      tbl[0].exp_ct = FIPS_CT;
      tbl[1] = mk(1'b0, FIPS_KEY, rand128(), 20, TO, 16'hFFFF, 1'b0);
      tbl[2] = mk(1'b0, FIPS_KEY, rand128(), 0, 0, 16'hFFFF, 1'b1);
      tbl[3] = mk(1'b0, FIPS_KEY, rand128(), 0, 0, 16'hFFFF, 1'b0);
      tbl[4] = mk(1'b1, rand128(), rand128(), 0, 2, 16'hFF59, 1'b0);
      cur_key = tbl[4].key;
      for (int i = 5; i < N_BLK; i++) begin
         nk = (i == N_BLK - 1) ? 1'b1 : 1'($urandom_range(1, 0));
         k  = nk ? rand128() : cur_key;
         cur_key = k;
         tbl[i] = mk(nk, k, rand128(), 0, int'($urandom_range(TO, 0)),
                     16'($urandom()) | 16'h0101, 1'b0);
      end

      #12;
      reset_state_checks();
      @(negedge clk);
      rst = 1'b1;

      // plaintext offered before any key: must be refused
      in_valid = 1'b1; in_key = 1'b0; in_data = 32'hdeadbeef;
      for (int i = 0; i < 3; i++) begin
         #1; chk1("pt_without_key", in_ready, 1'b0);
         @(negedge clk);
      end
      in_valid = 1'b0;

      for (int i = 0; i < N_BLK - 1; i++) run_block(tbl[i]);

      // reset asserted while the core is being waited on
      rand_i = rand_rv(); rand_valid = 1'b1;
      for (int j = 0; j < 4; j++) send_word($urandom(), 1'b0);
      @(negedge clk); #1;
      chk1("mid_rst_launch", cif.core_drdy_i, 1'b1);
      rand_valid = 1'b0;
      @(negedge clk); #1;
      chk1("mid_rst_in_wait", busy, 1'b1);
      #2;
      rst = 1'b0; #1;
      reset_state_checks();
      @(negedge clk); @(negedge clk);
      rst = 1'b1; err_exp = 1'b0; #1;
      reset_state_checks();

      run_block(tbl[N_BLK - 1]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clm_aes_host_ctrl.md
Name: clm_aes_host_ctrl

Overview:
- Initiator side of the CLM AES core handshake (plaintext/key/random_vect/p_det in, drdy_i pulse, wait drdy_o, ciphertext out).
- Assembles 128-bit key and plaintext from a 32-bit word stream and supplies fresh randomness and p_det per block.
- Launches the core and streams the ciphertext back as 4 words.
- Sits between the system bus/testbench front-end and one CLM AES core instance.

Parameters:
d, 4, redundancy degree; red_poly_t width = 8+d
TIMEOUT, 1023, max cycles in WAIT before abort (counter width = $clog2(TIMEOUT+1))

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, asynchronous, active-low (asserted when 0)
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid&&in_ready
in_data  in  32  key or plaintext word
in_key  in  1  1: word is key, 0: word is plaintext
rand_valid  in  1  fresh random vector and p_det available
rand_ack  out  1  one-cycle pulse: rand_i/p_det_i consumed
rand_i  in  23*(8+d)  randomness, element k at [k*(8+d)+:8+d]
p_det_i  in  p_det_t  modulus selector for this block
out_valid  out  1  ciphertext word valid
out_ready  in  1  sink ready
out_data  out  32  ciphertext word
busy  out  1  state != COLLECT
err  out  1  sticky timeout flag
core_plaintext  out  128  to core
core_key  out  128  to core
core_random_vect  out  23*(8+d)  to core, held stable from LAUNCH to end of WAIT
core_p_det  out  p_det_t  to core
core_drdy_i  out  1  start pulse
core_drdy_o  in  1  core done
core_ciphertext  in  128  core result, valid while core_drdy_o=1

Behaviour:
- Word k (k=0..3) of any 128-bit quantity maps to bits [32k+:32]; words arrive/leave k=0 first.
- Reset (rst=0, async): state=COLLECT, all registers 0, key_valid=0, err=0, word counters 0; all outputs 0 except in_ready, which follows its combinational rule.
- States: COLLECT, ARM, LAUNCH, WAIT, DRAIN.
- COLLECT: in_ready = in_key || key_valid.
  - Key word accepted: written at key_cnt, key_cnt wraps 3->0.
    - key_cnt==0 write clears key_valid.
    - key_cnt==3 write sets key_valid.
  - Plaintext word accepted: written at pt_cnt.
    - 4th word (pt_cnt==3) resets pt_cnt to 0 and sets next state ARM.
- ARM: in_ready=0. On rand_valid, latch rand_i and p_det_i, assert rand_ack for exactly that cycle, then LAUNCH. Stays in ARM indefinitely while rand_valid=0.
- LAUNCH: core_drdy_i=1 for exactly one cycle; clear wait counter; then WAIT.
- WAIT: counter increments each cycle.
  - core_drdy_o=1: latch core_ciphertext into ct register, then DRAIN.
  - Counter==TIMEOUT with no drdy_o: set err, return to COLLECT. Key is kept; plaintext is discarded.
  - drdy_o and timeout in the same cycle: drdy_o wins.
- DRAIN: out_valid=1, out_data=ct word out_cnt.
  - Advance on out_ready; hold data stable while out_ready=0.
  - After word 3 accepted: out_cnt=0, go to COLLECT.
- core_plaintext, core_key, core_random_vect and core_p_det are direct register outputs.
  - Key register is not writable outside COLLECT, so it is constant during a block.
- Latency:
  - Last plaintext word to core_drdy_i: 2 cycles if rand_valid is already high.
  - core_drdy_o to first out_valid: 1 cycle.
- err clears only on reset.
- Reset asserted mid-operation: immediate return to reset state; no partial output.

Decomposition:
- Package types additions:
  - host_state_t enum (COLLECT..DRAIN)
  - rand_vec_t = red_poly_t [0:22]
  - word_idx_t logic [1:0]
  - reuse existing p_det_t, red_poly_t
- One sub-module: host_word_buf. It is a 4x32 register with a write-index port and a 128-bit view, and is instantiated for key, plaintext and ciphertext (ct variant with parallel load).

Test Plan:
- FIPS-197 key words 03020100,07060504,0b0a0908,0f0e0d0c; plaintext 33221100,77665544,bbaa9988,ffeeddcc; rand_valid=1; core model -> out words d8e0c469,30047b6a,80b7cdd8,5ac5b470; drdy_i pulses exactly once.
- Plaintext word offered with key_valid=0 -> in_ready=0, no write. After 4 key words -> accepted.
- rand_valid held 0 for 20 cycles in ARM -> no core_drdy_i. Raise rand_valid -> one rand_ack, drdy_i next cycle, core_random_vect equals rand_i sampled at ack.
- Core model never raises drdy_o with TIMEOUT=15 -> err=1 after 16 WAIT cycles, state COLLECT, key retained. Second block then encrypts correctly.
- DRAIN with out_ready toggling 1,0,0,1,1,0,1 -> exactly 4 words in order, out_data stable while stalled.
- rst=0 asserted during WAIT (not on a clk edge) -> outputs zero immediately. After release, key_valid=0 and in_ready=in_key.
